vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 25 ++
 rtl/vram_arb_if.sv | 32 +++
 rtl/vram_arb_cpu_fsm.sv | 57 +++++
 rtl/vram_arbiter.sv | 81 ++++++++
 tb/tb_vram_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arb_pkg.sv
// Shared widths, default geometry and CPU handshake state encoding for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ST_W   = 2;

  localparam logic [ADDR_W-1:0] VGA_REGION_DEF = 16'h2000;
  localparam logic [ADDR_W-1:0] FB_WORDS_DEF   = 16'd1200;

  // CPU handshake states
  typedef logic [ST_W-1:0] cpu_state_t;
  localparam cpu_state_t ST_IDLE    = 2'd0;
  localparam cpu_state_t ST_BUSY    = 2'd1;
  localparam cpu_state_t ST_ACK     = 2'd2;
  localparam cpu_state_t ST_RELEASE = 2'd3;

  // One cycle of traffic on the single-port RAM
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wren;
  } mem_cmd_t;

endpackage

// File: rtl/vram_arb_if.sv
// Scanout, CPU and RAM signal bundle; slave is the arbiter's view, master the environment's.
interface vram_arb_if;
  import vram_arb_pkg::*;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_blank;
  logic [DATA_W-1:0] vga_q;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr, vga_blank, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    output vga_q, cpu_ack, cpu_rdata, mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output vga_req, vga_addr, vga_blank, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    input  vga_q, cpu_ack, cpu_rdata, mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/vram_arb_cpu_fsm.sv
// CPU handshake: grant when the RAM is free, ack two cycles later, then wait for cpu_req to drop.
module vram_arb_cpu_fsm
  import vram_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              window,
  input  logic [DATA_W-1:0] mem_q,
  output logic              grant_c,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata
);

  cpu_state_t state;
  cpu_state_t state_nxt;
  logic       rd_pend;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and same-cycle grant
  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req && window) begin
          grant_c   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY:    state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_RELEASE;
      ST_RELEASE: if (!cpu_req) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Ack pulse and read-data capture; the RAM answers during BUSY
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (grant_c) rd_pend <= !cpu_we;
      cpu_ack <= (state == ST_BUSY);
      if ((state == ST_BUSY) && rd_pend) cpu_rdata <= mem_q;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win every cycle, the CPU gets the idle cycles.
// Build option: VRAM_ARB_BLANK_ONLY_EN restricts CPU grants to scanout blanking intervals.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] VGA_REGION = VGA_REGION_DEF,
  parameter logic [ADDR_W-1:0] FB_WORDS   = FB_WORDS_DEF
)
(
  input  logic       clock,
  input  logic       reset_n,
  vram_arb_if.slave  bus
);

  logic     window_c;
  logic     grant_c;
  logic     vga_pend;
  mem_cmd_t cmd_c;
  mem_cmd_t hold_q;

  // Framebuffer size is descriptive only: scanout offsets are never clamped to it
  logic unused_fb_words;
  assign unused_fb_words = ^FB_WORDS;

`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign window_c = !bus.vga_req && bus.vga_blank;
`else
  logic unused_blank;
  assign unused_blank = bus.vga_blank;
  assign window_c     = !bus.vga_req;
`endif

  vram_arb_cpu_fsm u_cpu_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (bus.cpu_req),
    .cpu_we    (bus.cpu_we),
    .window    (window_c),
    .mem_q     (bus.mem_q),
    .grant_c   (grant_c),
    .cpu_ack   (bus.cpu_ack),
    .cpu_rdata (bus.cpu_rdata)
  );

  // RAM port mux: scanout, then granted CPU, else hold address/data with write off
  always_comb begin
    cmd_c      = hold_q;
    cmd_c.wren = 1'b0;
    if (!reset_n) begin
      cmd_c = '0;
    end else if (bus.vga_req) begin
      cmd_c.addr = ADDR_W'(VGA_REGION + bus.vga_addr);
    end else if (grant_c) begin
      cmd_c.addr  = bus.cpu_addr;
      cmd_c.wdata = bus.cpu_wdata;
      cmd_c.wren  = bus.cpu_we;
    end
  end

  assign bus.mem_addr  = cmd_c.addr;
  assign bus.mem_wdata = cmd_c.wdata;
  assign bus.mem_wren  = cmd_c.wren;

  // Remember the last address/data presented so idle cycles keep the RAM port steady
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else          hold_q <= cmd_c;
  end

  // Scanout read pipeline: capture mem_q the cycle after the address went out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_pend  <= 1'b0;
      bus.vga_q <= '0;
    end else begin
      vga_pend <= bus.vga_req;
      if (vga_pend) bus.vga_q <= bus.mem_q;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  vram_arb_if bus ();

  vram_arbiter #(.VGA_REGION(16'h2000), .FB_WORDS(16'd1200)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: never-written words read back a fixed pattern of their address
  logic [15:0] ram     [65536];
  bit          wr_seen [65536];

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ram_rd(input logic [15:0] a);
    return wr_seen[a] ? ram[a] : pat(a);
  endfunction

  always @(posedge clock) begin
    if (bus.mem_wren) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      wr_seen[bus.mem_addr] <= 1'b1;
    end
    bus.mem_q <= ram_rd(bus.mem_addr);
  end

  // Reference memory contents as the specification says they should evolve
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle_in();
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.vga_blank = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic test_reset();
    idle_in();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    bus.vga_req = 1'b1; bus.vga_addr = 16'd7;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2100; bus.cpu_wdata = 16'h1111;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.cpu_ack); end
    checks++; if (bus.cpu_rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", bus.cpu_rdata); end
    checks++; if (bus.vga_q !== 16'h0) begin failures++; $display("FAIL rst_vga_q got=%h exp=0000", bus.vga_q); end
    checks++; if (bus.mem_wren !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", bus.mem_wren); end
    checks++; if (bus.mem_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0000", bus.mem_wdata); end
    idle_in();
    @(negedge clock);
    reset_n = 1'b1;
    tick(); mid();
    checks++; if (bus.mem_wren !== 1'b0 || bus.mem_addr !== 16'h0) begin
      failures++; $display("FAIL post_rst_idle got=%b/%h exp=0/0000", bus.mem_wren, bus.mem_addr); end
  endtask

  task automatic test_scanout();
    logic [15:0] addrs [8];
    tick();
    bus.vga_req = 1'b1; bus.vga_addr = 16'd5;
    mid();
    checks++; if (bus.mem_addr !== 16'h2005 || bus.mem_wren !== 1'b0) begin
      failures++; $display("FAIL scan_addr got=%h/%b exp=2005/0", bus.mem_addr, bus.mem_wren); end
    tick(); bus.vga_req = 1'b0;
    tick(); mid();
    checks++; if (bus.vga_q !== ref_rd(16'h2005)) begin
      failures++; $display("FAIL scan_q got=%h exp=%h", bus.vga_q, ref_rd(16'h2005)); end
    repeat (3) tick();
    mid();
    checks++; if (bus.vga_q !== ref_rd(16'h2005)) begin
      failures++; $display("FAIL scan_hold got=%h exp=%h", bus.vga_q, ref_rd(16'h2005)); end
    // Back-to-back burst including out-of-range and wrapping offsets
    addrs[0] = 16'd1199; addrs[1] = 16'd1200; addrs[2] = 16'hFFFF; addrs[3] = 16'hE000;
    for (int i = 4; i < 8; i++) addrs[i] = 16'($urandom_range(0, 1199));
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k < 8) begin bus.vga_req = 1'b1; bus.vga_addr = addrs[k]; end
      else bus.vga_req = 1'b0;
      mid();
      if (k < 8) begin
        checks++; if (bus.mem_addr !== 16'(16'h2000 + addrs[k]) || bus.mem_wren !== 1'b0) begin
          failures++; $display("FAIL burst_addr k=%0d got=%h exp=%h", k, bus.mem_addr, 16'(16'h2000 + addrs[k])); end
      end
      if (k >= 2) begin
        checks++; if (bus.vga_q !== ref_rd(16'(16'h2000 + addrs[k-2]))) begin
          failures++; $display("FAIL burst_q k=%0d got=%h exp=%h", k, bus.vga_q, ref_rd(16'(16'h2000 + addrs[k-2]))); end
      end
    end
    idle_in();
    repeat (2) tick();
  endtask

  task automatic test_cpu_write();
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2010; bus.cpu_wdata = 16'hABCD;
    mid();
    checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 16'h2010 || bus.mem_wdata !== 16'hABCD) begin
      failures++; $display("FAIL wr_grant got=%b/%h/%h exp=1/2010/abcd", bus.mem_wren, bus.mem_addr, bus.mem_wdata); end
    ref_mem[16'h2010] = 16'hABCD;
    tick();
    bus.cpu_addr = 16'h1234; bus.cpu_wdata = 16'h0000; bus.cpu_we = 1'b1;
    mid();
    checks++; if (bus.mem_wren !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      failures++; $display("FAIL wr_busy got=%b/%b exp=0/0", bus.mem_wren, bus.cpu_ack); end
    tick(); mid();
    checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", bus.cpu_ack); end
    tick(); bus.cpu_req = 1'b0; mid();
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%b exp=0", bus.cpu_ack); end
    checks++; if (ram_rd(16'h2010) !== 16'hABCD || wr_seen[16'h1234]) begin
      failures++; $display("FAIL wr_ram got=%h exp=abcd", ram_rd(16'h2010)); end
    checks++; if (bus.mem_addr !== 16'h2010 || bus.mem_wdata !== 16'hABCD || bus.mem_wren !== 1'b0) begin
      failures++; $display("FAIL idle_hold got=%h/%h exp=2010/abcd", bus.mem_addr, bus.mem_wdata); end
    idle_in();
    repeat (2) tick();
  endtask

  task automatic test_cpu_read();
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'h2010 : 16'(16'h2000 + $urandom_range(0, 1199));
      tick();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.cpu_wdata = 16'($urandom);
      mid();
      checks++; if (bus.mem_wren !== 1'b0 || bus.mem_addr !== a) begin
        failures++; $display("FAIL rd_grant i=%0d got=%b/%h exp=0/%h", i, bus.mem_wren, bus.mem_addr, a); end
      tick(); tick(); mid();
      checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== ref_rd(a)) begin
        failures++; $display("FAIL rd_data i=%0d got=%b/%h exp=1/%h", i, bus.cpu_ack, bus.cpu_rdata, ref_rd(a)); end
      tick(); bus.cpu_req = 1'b0;
    end
    idle_in();
    repeat (2) tick();
  endtask

  task automatic test_contention();
    logic [15:0] va;
    int          bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      va = 16'($urandom_range(0, 1199));
      bus.vga_req = 1'b1; bus.vga_addr = va;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2222; bus.cpu_wdata = 16'h7E57;
      mid();
      if (bus.mem_wren !== 1'b0 || bus.mem_addr !== 16'(16'h2000 + va)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL cont_blocked bad_cycles=%0d exp=0", bad); end
    tick(); bus.vga_req = 1'b0; mid();
    checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 16'h2222 || bus.mem_wdata !== 16'h7E57) begin
      failures++; $display("FAIL cont_grant got=%b/%h/%h exp=1/2222/7e57", bus.mem_wren, bus.mem_addr, bus.mem_wdata); end
    ref_mem[16'h2222] = 16'h7E57;
    tick(); tick(); mid();
    checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL cont_ack got=%b exp=1", bus.cpu_ack); end
    idle_in();
    repeat (2) tick();
  endtask

  task automatic test_back_to_back_held();
    int n_wr;
    int n_ack;
    n_wr = 0; n_ack = 0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2333; bus.cpu_wdata = 16'h0F0F;
    ref_mem[16'h2333] = 16'h0F0F;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin tick(); bus.cpu_wdata = 16'($urandom); end
      mid();
      if (bus.mem_wren === 1'b1) n_wr++;
      if (bus.cpu_ack === 1'b1) n_ack++;
    end
    checks++; if (n_wr != 1 || n_ack != 1) begin
      failures++; $display("FAIL held_once writes=%0d acks=%0d exp=1/1", n_wr, n_ack); end
    tick(); bus.cpu_req = 1'b0;
    tick(); bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2333;
    mid();
    checks++; if (bus.mem_addr !== 16'h2333 || bus.mem_wren !== 1'b0) begin
      failures++; $display("FAIL held_regrant got=%h/%b exp=2333/0", bus.mem_addr, bus.mem_wren); end
    tick(); tick(); mid();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'h0F0F) begin
      failures++; $display("FAIL held_rdata got=%b/%h exp=1/0f0f", bus.cpu_ack, bus.cpu_rdata); end
    idle_in();
    repeat (2) tick();
  endtask

  task automatic test_reset_busy();
    int n_ack;
    n_ack = 0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2444; bus.cpu_wdata = 16'hBEEF;
    mid();
    checks++; if (bus.mem_wren !== 1'b1) begin failures++; $display("FAIL rb_grant got=%b exp=1", bus.mem_wren); end
    ref_mem[16'h2444] = 16'hBEEF;
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 16'h0 || bus.vga_q !== 16'h0 ||
                  bus.mem_wren !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
      failures++; $display("FAIL rb_outputs got=%b/%h/%h/%b/%h/%h exp=all zero", bus.cpu_ack, bus.cpu_rdata,
                           bus.vga_q, bus.mem_wren, bus.mem_addr, bus.mem_wdata); end
    tick();
    idle_in();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); mid();
      if (bus.cpu_ack === 1'b1) n_ack++;
    end
    checks++; if (n_ack != 0) begin failures++; $display("FAIL rb_no_ack acks=%0d exp=0", n_ack); end
    checks++; if (ram_rd(16'h2444) !== 16'hBEEF) begin
      failures++; $display("FAIL rb_write_kept got=%h exp=beef", ram_rd(16'h2444)); end
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2444;
    mid();
    checks++; if (bus.mem_addr !== 16'h2444 || bus.mem_wren !== 1'b0) begin
      failures++; $display("FAIL rb_idle_grant got=%h/%b exp=2444/0", bus.mem_addr, bus.mem_wren); end
    tick(); tick(); mid();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin
      failures++; $display("FAIL rb_readback got=%b/%h exp=1/beef", bus.cpu_ack, bus.cpu_rdata); end
    idle_in();
    repeat (2) tick();
  endtask

  task automatic test_blank();
    int n_wr;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.vga_blank = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2555; bus.cpu_wdata = 16'h5555;
      mid();
      if (bus.mem_wren === 1'b1) n_wr++;
    end
`ifdef VRAM_ARB_BLANK_ONLY_EN
    checks++; if (n_wr != 0) begin failures++; $display("FAIL blank_wait writes=%0d exp=0", n_wr); end
    tick(); bus.vga_blank = 1'b1; mid();
    checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 16'h2555) begin
      failures++; $display("FAIL blank_grant got=%b/%h exp=1/2555", bus.mem_wren, bus.mem_addr); end
`else
    checks++; if (n_wr != 1) begin failures++; $display("FAIL blank_ignored writes=%0d exp=1", n_wr); end
`endif
    ref_mem[16'h2555] = 16'h5555;
    repeat (3) tick();
    idle_in();
    repeat (3) tick();
  endtask

  task automatic test_random();
    int          c;
    int          last_g;
    bit          dropped;
    bit          granted;
    bit          wind_down;
    bit          grant;
    bit          win;
    bit          vq_known;
    bit          exp_ack;
    bit          pend_we;
    logic        vreq, creq, cwe, exp_wren;
    logic [15:0] vaddr, caddr, cwdata;
    logic [15:0] exp_addr, exp_wdata, h_addr, h_wdata, exp_rd, exp_vq;
    logic [15:0] vq_data [$];
    int          vq_due  [$];
    c = 0; last_g = -100; dropped = 1'b1; granted = 1'b0; wind_down = 1'b0; vq_known = 1'b0;
    pend_we = 1'b0; exp_rd = '0; exp_vq = '0; h_addr = '0; h_wdata = '0;
    creq = 1'b0; cwe = 1'b0; caddr = '0; cwdata = '0;
    while (c < 450 && (c < 400 || !(dropped && c >= last_g + 4))) begin
      tick();
      wind_down = (c >= 400);
      if (c == 0) begin
        vreq = 1'b0; vaddr = '0; bus.vga_blank = 1'b1;
        creq = 1'b1; cwe = 1'b1; caddr = 16'h2600; cwdata = 16'($urandom);
      end else begin
        vreq = !wind_down && ($urandom_range(0, 99) < 40);
        vaddr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1199));
        bus.vga_blank = wind_down ? 1'b1 : 1'($urandom_range(0, 1));
        if (!creq) begin
          if (!wind_down && c > last_g + 2 && $urandom_range(0, 2) == 0) begin
            creq = 1'b1; granted = 1'b0; cwe = 1'($urandom_range(0, 1));
            caddr = 16'(16'h2000 + $urandom_range(0, 1199)); cwdata = 16'($urandom);
          end
        end else if (granted) begin
          caddr = 16'($urandom); cwdata = 16'($urandom); cwe = 1'($urandom_range(0, 1));
          if (c > last_g + 2 && (wind_down || $urandom_range(0, 1) == 0)) creq = 1'b0;
        end
      end
      bus.vga_req = vreq; bus.vga_addr = vaddr;
      bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwdata;
`ifdef VRAM_ARB_BLANK_ONLY_EN
      win = !vreq && bus.vga_blank;
`else
      win = !vreq;
`endif
      grant = creq && win && dropped && (c >= last_g + 4);
      exp_wren = 1'b0; exp_addr = h_addr; exp_wdata = h_wdata;
      if (vreq) begin
        exp_addr = 16'(16'h2000 + vaddr);
        vq_data.push_back(ref_rd(exp_addr));
        vq_due.push_back(c + 2);
      end else if (grant) begin
        exp_addr = caddr; exp_wdata = cwdata; exp_wren = cwe;
        last_g = c; dropped = 1'b0; granted = 1'b1; pend_we = cwe;
        if (cwe) ref_mem[caddr] = cwdata;
        else     exp_rd = ref_rd(caddr);
      end
      h_addr = exp_addr; h_wdata = exp_wdata;
      if (c >= last_g + 3 && !creq) dropped = 1'b1;
      exp_ack = (c == last_g + 2);
      if (vq_due.size() > 0 && vq_due[0] == c) begin
        exp_vq = vq_data.pop_front(); void'(vq_due.pop_front()); vq_known = 1'b1;
      end
      mid();
      checks++; if (bus.mem_wren !== exp_wren || bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wdata) begin
        failures++; $display("FAIL rnd_mem c=%0d got=%b/%h/%h exp=%b/%h/%h", c, bus.mem_wren, bus.mem_addr,
                             bus.mem_wdata, exp_wren, exp_addr, exp_wdata); end
      checks++; if (bus.cpu_ack !== exp_ack) begin
        failures++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, bus.cpu_ack, exp_ack); end
      if (exp_ack && !pend_we) begin
        checks++; if (bus.cpu_rdata !== exp_rd) begin
          failures++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, bus.cpu_rdata, exp_rd); end
      end
      if (vq_known) begin
        checks++; if (bus.vga_q !== exp_vq) begin
          failures++; $display("FAIL rnd_vga_q c=%0d got=%h exp=%h", c, bus.vga_q, exp_vq); end
      end
      c++;
    end
    checks++; if (!(dropped && c >= last_g + 4)) begin
      failures++; $display("FAIL rnd_drain c=%0d last_grant=%0d exp=drained", c, last_g); end
    idle_in();
    repeat (2) tick();
    foreach (ref_mem[a]) begin
      checks++; if (ram_rd(a) !== ref_mem[a]) begin
        failures++; $display("FAIL ram_final addr=%h got=%h exp=%h", a, ram_rd(a), ref_mem[a]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_scanout();
    test_cpu_write();
    test_cpu_read();
    test_contention();
    test_back_to_back_held();
    test_reset_busy();
    test_blank();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
